// File: rtl/note_detector.sv
// ---------------------------------------------------------------------------
// note_detector
//
// Measures the period of a square-wave tone and decodes it back to the 4-bit
// note code (1..14) that the tone generator used. A code is reported only
// after CONFIRM consecutive measured periods agree. Long silence (no rising
// edge for TIMEOUT clocks) drops the note and waits for a fresh reference edge.
//
// Parameters
//   TOL      max |measured - nominal| period error (clocks) for a match
//   CONFIRM  consecutive equal-code periods required to update note (1..7)
//   TIMEOUT  clocks without a rising edge before declaring silence (<= 524287)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       0 = synchronously clear all state to reset values
//   tone_in      asynchronous square-wave tone input
//   note         decoded note code, 0 = silence or unmatched
//   note_valid   1 while note holds a confirmed code 1..14
//   note_change  1-cycle pulse whenever note or note_valid changes
//   period       last measured period in clocks
//   miss_cnt     saturating count of unmatched periods
//
// Build option
//   NOTE_DET_STATS_EN  when defined, miss_cnt counts unmatched periods
//                      (saturating at 255); otherwise it is tied to zero.
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_SILENT | no reference edge yet; next rising edge only starts timing
//   ST_ARMED  | timing from the previous edge; each edge yields a measurement
// ---------------------------------------------------------------------------
module note_detector #(
    parameter int TOL     = 2048,
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tone_in,
    output logic [3:0]  note,
    output logic        note_valid,
    output logic        note_change,
    output logic [18:0] period,
    output logic [7:0]  miss_cnt
);

    localparam logic [0:0]  ST_SILENT = 1'b0;
    localparam logic [0:0]  ST_ARMED  = 1'b1;

    localparam logic [18:0] TOL_W     = 19'(TOL);
    localparam logic [18:0] TIMEOUT_W = 19'(TIMEOUT);
    localparam logic [2:0]  CONFIRM_W = 3'(CONFIRM);

    // Nominal tone periods in clocks, indexed by note code.
    function automatic logic [18:0] nominal(input logic [3:0] code);
        logic [18:0] p;
        case (code)
            4'd1:    p = 19'd382220;
            4'd2:    p = 19'd340531;
            4'd3:    p = 19'd303371;
            4'd4:    p = 19'd286345;
            4'd5:    p = 19'd255103;
            4'd6:    p = 19'd227274;
            4'd7:    p = 19'd202479;
            4'd8:    p = 19'd191114;
            4'd9:    p = 19'd170263;
            4'd10:   p = 19'd151686;
            4'd11:   p = 19'd143173;
            4'd12:   p = 19'd127554;
            4'd13:   p = 19'd113637;
            4'd14:   p = 19'd101239;
            default: p = 19'd0;
        endcase
        return p;
    endfunction

    // The table spacing exceeds 2*TOL, so at most one entry can match.
    function automatic logic [3:0] classify(input logic [18:0] p);
        logic [3:0]  c;
        logic [18:0] nom;
        logic [18:0] diff;
        c = 4'd0;
        for (int k = 1; k <= 14; k++) begin
            nom  = nominal(4'(k));
            diff = (p >= nom) ? (p - nom) : (nom - p);
            if (diff <= TOL_W) begin
                c = 4'(k);
            end
        end
        return c;
    endfunction

    logic        sync1;
    logic        sync2;
    logic        tone_d;
    logic        rise;

    logic [0:0]  state;
    logic [18:0] cnt;
    logic [19:0] cnt_inc;
    logic [18:0] meas;
    logic [3:0]  meas_code;
    logic        measure;
    logic        timeout_hit;

    logic [3:0]  cand_code;
    logic [2:0]  cand_cnt;
    logic        confirm_upd;

    // Two-flop synchronizer followed by a rising-edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            tone_d <= 1'b0;
        end else if (!enable) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            tone_d <= 1'b0;
        end else begin
            sync1  <= tone_in;
            sync2  <= sync1;
            tone_d <= sync2;
        end
    end

    assign rise = sync2 & ~tone_d;

    // The counter holds clocks elapsed since the last edge minus one, so the
    // edge cycle itself is added back; 20 bits avoids wrap at TIMEOUT=524287.
    assign cnt_inc   = {1'b0, cnt} + 20'd1;
    assign meas      = (cnt_inc > {1'b0, TIMEOUT_W}) ? TIMEOUT_W : cnt_inc[18:0];
    assign meas_code = classify(meas);

    // An edge arriving in the timeout cycle wins and is measured instead.
    assign measure     = (state == ST_ARMED) && rise;
    assign timeout_hit = (state == ST_ARMED) && !rise && (cnt == TIMEOUT_W);

    assign confirm_upd = (cand_cnt >= CONFIRM_W) &&
                         ((cand_code != note) || ((cand_code != 4'd0) != note_valid));

    // Period timer and FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_SILENT;
            cnt    <= 19'd0;
            period <= 19'd0;
        end else if (!enable) begin
            state  <= ST_SILENT;
            cnt    <= 19'd0;
            period <= 19'd0;
        end else begin
            if (rise) begin
                cnt <= 19'd0;
            end else if (cnt != TIMEOUT_W) begin
                cnt <= cnt + 19'd1;
            end

            case (state)
                ST_SILENT: begin
                    if (rise) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (rise) begin
                        period <= meas;
                    end else if (cnt == TIMEOUT_W) begin
                        state <= ST_SILENT;
                    end
                end
                default: state <= ST_SILENT;
            endcase
        end
    end

    // Candidate tracking: run length of identical consecutive codes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_code <= 4'd0;
            cand_cnt  <= 3'd0;
        end else if (!enable) begin
            cand_code <= 4'd0;
            cand_cnt  <= 3'd0;
        end else if (measure) begin
            if (meas_code == cand_code) begin
                if (cand_cnt != 3'd7) begin
                    cand_cnt <= cand_cnt + 3'd1;
                end
            end else begin
                cand_code <= meas_code;
                cand_cnt  <= 3'd1;
            end
        end else if (timeout_hit) begin
            cand_code <= 4'd0;
            cand_cnt  <= 3'd0;
        end
    end

    // Reported note. The candidate is registered at the edge, so a confirmed
    // code lands one clock after the confirming edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note        <= 4'd0;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else if (!enable) begin
            note        <= 4'd0;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else if (timeout_hit) begin
            note        <= 4'd0;
            note_valid  <= 1'b0;
            note_change <= note_valid;
        end else if (confirm_upd) begin
            note        <= cand_code;
            note_valid  <= (cand_code != 4'd0);
            note_change <= 1'b1;
        end else begin
            note_change <= 1'b0;
        end
    end

`ifdef NOTE_DET_STATS_EN
    logic [7:0] miss_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_q <= 8'd0;
        end else if (!enable) begin
            miss_q <= 8'd0;
        end else if (measure && (meas_code == 4'd0) && (miss_q != 8'hff)) begin
            miss_q <= miss_q + 8'd1;
        end
    end

    assign miss_cnt = miss_q;
`else
    assign miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_note_detector.sv
module tb_note_detector;

    localparam int TOL     = 2048;
    localparam int CONFIRM = 2;
    localparam int TIMEOUT = 400000;

    localparam int P [1:14] = '{382220, 340531, 303371, 286345, 255103,
                                227274, 202479, 191114, 170263, 151686,
                                143173, 127554, 113637, 101239};

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tone_in;
    logic [3:0]  note;
    logic        note_valid;
    logic        note_change;
    logic [18:0] period;
    logic [7:0]  miss_cnt;

    note_detector #(.TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tone_in     (tone_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_change (note_change),
        .period      (period),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: history of decoded codes since the last
    // reference edge, plus the expected visible outputs.
    bit       m_armed;
    int       hist[$];
    int       m_note;
    bit       m_valid;
    int       m_period;
    int       m_miss;
    int       pend;
    int       chg_exp;
    int       chg_seen = 0;

    always @(posedge clk) begin
        if (note_change === 1'b1) chg_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int classify(input int p);
        for (int k = 1; k <= 14; k++) begin
            if ((p - P[k] <= TOL) && (P[k] - p <= TOL)) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_armed  = 0;
        hist.delete();
        m_note   = 0;
        m_valid  = 0;
        m_period = 0;
        m_miss   = 0;
    endtask

    task automatic model_rise(output bit pulse);
        int  d;
        int  c;
        bit  run;
        pulse = 0;
        if (!m_armed) begin
            m_armed = 1;
        end else begin
            d = (pend > TIMEOUT) ? TIMEOUT : pend;
            m_period = d;
            c = classify(d);
            if (c == 0 && m_miss < 255) m_miss++;
            hist.push_back(c);
            if (hist.size() > 8) void'(hist.pop_front());
            run = (hist.size() >= CONFIRM);
            for (int i = 0; i < CONFIRM; i++) begin
                if (run && hist[hist.size() - 1 - i] != c) run = 0;
            end
            if (run && (c != m_note || (c != 0) != m_valid)) begin
                m_note  = c;
                m_valid = (c != 0);
                pulse   = 1;
                chg_exp++;
            end
        end
    endtask

    function automatic int exp_miss();
`ifdef NOTE_DET_STATS_EN
        return m_miss;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string tag, input bit pulse);
        chk({tag, ".note"},   {28'd0, note},        m_note);
        chk({tag, ".valid"},  {31'd0, note_valid},  {31'd0, m_valid});
        chk({tag, ".change"}, {31'd0, note_change}, {31'd0, pulse});
        chk({tag, ".period"}, {13'd0, period},      m_period);
        chk({tag, ".miss"},   {24'd0, miss_cnt},    exp_miss());
    endtask

    // One full tone period starting with a rising edge (caller is just past a
    // negedge). The measurement of the previous period is checked 4 negedges
    // after the rise: sync (2) + edge register (1) + note update (1).
    task automatic rise_and_check(input string tag);
        bit pulse;
        chk({tag, ".pulses"}, chg_seen, chg_exp);
        tone_in = 1'b1;
        model_rise(pulse);
        repeat (4) @(negedge clk);
        check_outputs(tag, pulse);
    endtask

    task automatic do_period(input string tag, input int per);
        rise_and_check(tag);
        repeat (per / 2 - 4) @(negedge clk);
        tone_in = 1'b0;
        repeat (per - per / 2) @(negedge clk);
        pend = per;
    endtask

    initial begin
        int k;
        int per;

        reset   = 1'b0;
        enable  = 1'b1;
        tone_in = 1'b0;
        pend    = 0;
        chg_exp = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Lock on note 1 from silence.
        do_period("t1_arm", P[1]);
        do_period("t1_m1",  P[1]);
        do_period("t1_m2",  P[1]);

        // Switch straight to note 14.
        do_period("t2_a", P[14]);
        do_period("t2_b", P[14]);
        do_period("t2_c", P[14]);

        // Just outside tolerance of note 5 -> unmatched.
        do_period("t3_a", P[5] + TOL + 1);
        do_period("t3_b", P[5] + TOL + 1);
        do_period("t3_c", P[5] + TOL + 1);

        // Lock on 5 using periods exactly at the tolerance edges, then a
        // period whose edge coincides with the timeout (edge wins, clamped).
        do_period("t4_hi",   P[5] + TOL);
        do_period("t4_lo",   P[5] - TOL);
        do_period("t4_long", TIMEOUT + 1);

        // Last edge, then hold low until the timeout fires.
        rise_and_check("t4_last");
        repeat (10) @(negedge clk);
        tone_in = 1'b0;
        repeat (TIMEOUT + 3 - 14) @(negedge clk);
        chk("t4_pre_to.note",  {28'd0, note},       m_note);
        chk("t4_pre_to.valid", {31'd0, note_valid}, {31'd0, m_valid});
        @(negedge clk);
        m_armed = 0;
        hist.delete();
        if (m_valid) chg_exp++;
        m_note  = 0;
        m_valid = 0;
        check_outputs("t4_timeout", 1'b1);
        repeat (20) @(negedge clk);

        // Re-arm and lock on 14, then an asynchronous reset mid-period.
        do_period("t5_arm", P[14]);
        do_period("t5_m1",  P[14]);
        do_period("t5_m2",  P[14]);
        repeat (1000) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("t5_reset", 1'b0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_period("t5_rearm", P[14]);
        do_period("t5_r1",    P[14]);
        do_period("t5_r2",    P[14]);

        // enable low clears synchronously and ignores tone_in.
        repeat (500) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs("en_off", 1'b0);
        repeat (3) begin
            tone_in = 1'b1;
            repeat (5) @(negedge clk);
            tone_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        check_outputs("en_ignore", 1'b0);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Alternating periods never confirm.
        do_period("t6_arm", P[8]);
        do_period("t6_a",   P[9]);
        do_period("t6_b",   P[8]);
        do_period("t6_c",   P[9]);

        // Randomized pairs of short-note periods, in or out of tolerance.
        for (int n = 0; n < 5; n++) begin
            k = $urandom_range(10, 14);
            for (int r = 0; r < 2; r++) begin
                if ($urandom_range(0, 3) == 3)
                    per = P[k] + TOL + 1 + int'($urandom_range(0, 4000));
                else
                    per = P[k] + int'($urandom_range(0, 2 * TOL)) - TOL;
                do_period($sformatf("rnd%0d_%0d", n, r), per);
            end
        end

        rise_and_check("final");
        repeat (5) @(negedge clk);
        chk("final.pulses", chg_seen, chg_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
